bus_out_port: RTL and testbench

- Bus-side output peripheral, the responder at the far end of the controller's enable/load strobe protocol.
- Captures 16-bit words that the controller places on the shared bus when `load` is strobed, and buffers them in a small FIFO.
- Shows each word on the board LEDs for a fixed hold time, then advances to the next word.
- Drives a status read-back word into the bus mux when `en` is asserted, so programs can poll for space.

---
 rtl/bus_out_port_pkg.sv | 19 +
 rtl/bus_out_port_if.sv | 29 ++
 rtl/bus_out_port_sync_fifo.sv | 54 +++++
 rtl/bus_out_port.sv | 121 ++++++++++++
 tb/tb_bus_out_port.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/bus_out_port_pkg.sv
// Shared types and status-word layout for the bus output port.
package bus_out_port_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int OVF_BIT   = 15;
  localparam int FULL_BIT  = 14;
  localparam int EMPTY_BIT = 13;
  localparam int SHOW_BIT  = 12;
  localparam int CNT_LSB   = 8;
  localparam int DISP_LSB  = 0;
  localparam int CNT_FW    = 4;
  localparam int DISP_FW   = 8;
  localparam int STATUS_W  = 16;

endpackage

// File: rtl/bus_out_port_if.sv
// Bus-side signal bundle between the controller (master) and the output port (slave).
interface bus_out_port_if #(
  parameter int WIDTH = 16,
  parameter int LED_W = 5
);
  import bus_out_port_pkg::*;

  // load: one-cycle write strobe, bus sampled on that rising edge; the
  // controller must not strobe while full=1. en: selects status onto out.
  logic [WIDTH-1:0] bus;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [LED_W-1:0] leds;
  logic             full;
  logic             empty;
  state_t           dbg_state;

  modport master (
    output bus, load, en,
    input  out, leds, full, empty, dbg_state
  );

  modport slave (
    input  bus, load, en,
    output out, leds, full, empty, dbg_state
  );

endinterface

// File: rtl/bus_out_port_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through dout; a push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_out_port.sv
// Bus output port: FIFO-buffered words shown on LEDs for HOLD_CYCLES each,
// plus a polled status word. Define BUS_OUT_PORT_BYPASS_EN for zero-latency idle writes.
module bus_out_port
  import bus_out_port_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int LED_W       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_out_port_if.slave   bif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] display;
  logic             overflow;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic             hold_done;
  logic             pop;
  logic             push;
  logic             bypass;
  logic             drop;
  logic [STATUS_W-1:0] status;
  logic             unused_display_hi;

  assign hold_done = (state == SHOW) && (hold_cnt == '0);
  assign pop       = !fifo_empty && ((state == IDLE) || hold_done);

`ifdef BUS_OUT_PORT_BYPASS_EN
  assign bypass = bif.load && (state == IDLE) && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = bif.load && !bypass;
  assign drop = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bif.bus),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      display  <= '0;
      overflow <= 1'b0;
    end else begin
      // A dropped push on the same edge as a read-back keeps the flag set.
      if (drop)        overflow <= 1'b1;
      else if (bif.en) overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            display  <= fifo_dout;
            hold_cnt <= HOLD_INIT;
            state    <= SHOW;
          end else if (bypass) begin
            display  <= bif.bus;
            hold_cnt <= HOLD_INIT;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (pop) begin
            display  <= fifo_dout;
            hold_cnt <= HOLD_INIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status                        = '0;
    status[OVF_BIT]               = overflow;
    status[FULL_BIT]              = fifo_full;
    status[EMPTY_BIT]             = fifo_empty;
    status[SHOW_BIT]              = (state == SHOW);
    status[CNT_LSB +: CNT_FW]     = CNT_FW'(fifo_count);
    status[DISP_LSB +: DISP_FW]   = display[DISP_FW-1:0];
  end

  assign bif.out       = bif.en ? WIDTH'(status) : '0;
  assign bif.leds      = display[LED_W-1:0];
  assign bif.full      = fifo_full;
  assign bif.empty     = fifo_empty;
  assign bif.dbg_state = state;

  assign unused_display_hi = ^display[WIDTH-1:DISP_FW];

endmodule

// File: tb/tb_bus_out_port.sv
// Self-checking bench for bus_out_port: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based display-timeline model.
module tb_bus_out_port;
  import bus_out_port_pkg::*;

  localparam int W = 16;
  localparam int D = 4;
  localparam int H = 4;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bus_out_port_if #(.WIDTH(W), .LED_W(L)) bif ();

  bus_out_port #(
    .WIDTH       (W),
    .DEPTH       (D),
    .HOLD_CYCLES (H),
    .LED_W       (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Model: queued words, the word on display and how many cycles it has been shown.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_disp;
  bit           m_busy;
  int           m_shown;
  bit           m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] exp_status();
    int sz = mq.size();
    return {m_ovf, (sz == D), (sz == 0), m_busy, 4'(sz), m_disp[7:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_disp  = '0;
    m_busy  = 0;
    m_shown = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(input logic ld, input logic [W-1:0] b, input logic e);
    int pre    = mq.size();
    bit popped = 0;
    bit drop   = 0;
    bit byp    = 0;
`ifdef BUS_OUT_PORT_BYPASS_EN
    byp = ld && !m_busy && (pre == 0);
`endif
    if (!m_busy || m_shown == H) begin
      if (pre > 0) begin
        m_disp  = mq.pop_front();
        m_busy  = 1;
        m_shown = 1;
        popped  = 1;
      end else if (byp) begin
        m_disp  = b;
        m_busy  = 1;
        m_shown = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_shown++;
    end
    if (ld && !byp) begin
      if (pre < D || popped) mq.push_back(b);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (e) m_ovf = 0;
  endtask

  task automatic step(input logic ld, input logic [W-1:0] b, input logic e);
    @(negedge clk);
    bif.load = ld;
    bif.bus  = b;
    bif.en   = e;
    #1;
    chk("out",   bif.out, e ? 32'(exp_status()) : 32'h0);
    chk("leds",  bif.leds, m_disp[L-1:0]);
    chk("full",  bif.full, mq.size() == D);
    chk("empty", bif.empty, mq.size() == 0);
    chk("state", bif.dbg_state == SHOW, m_busy);
    model_edge(ld, b, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.load = 1'b0;
    bif.en   = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_leds",  bif.leds, 0);
    chk("rst_empty", bif.empty, 1);
    chk("rst_full",  bif.full, 0);
    chk("rst_out",   bif.out, 32'h2000);
    chk("rst_state", bif.dbg_state == SHOW, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bif.bus  = '0;
    bif.load = 1'b0;
    bif.en   = 1'b0;
    model_reset();

    // Reset then idle
    do_reset();
    repeat (3) step(0, 0, 1);

    // Single write held for H cycles, then back to idle
    step(1, 16'h001F, 0);
    repeat (8) step(0, 0, 1);
    chk("single_leds", bif.leds, 5'b11111);

    // Burst of five back-to-back writes
    for (int i = 1; i <= 5; i++) step(1, 16'(i), 1);
    repeat (26) step(0, 0, 1);
    chk("burst_last", bif.leds, 5'd5);

    // Overflow: seventh back-to-back write is dropped; en on that edge loses to the set
    for (int i = 1; i <= 6; i++) step(1, 16'(16'h40 + i), 0);
    step(1, 16'h00EE, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    repeat (30) step(0, 0, 0);

    // Reset while showing with three words queued
    for (int i = 1; i <= 4; i++) step(1, 16'(16'h10 + i), 0);
    chk("pre_rst_q", mq.size(), 3);
    do_reset();
    repeat (10) step(0, 0, 1);

    // Write while idle/empty (bypass build shows it immediately)
    step(1, 16'h000A, 1);
    step(0, 0, 1);
    repeat (8) step(0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom_range(0, 1)));
      if (i == 300) do_reset();
    end
    repeat (30) step(0, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
